// File: rtl/uncache_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge_pkg
// Shared definitions for the uncached LSU -> AXI4 bridge:
//   uc_state_t        bridge FSM state (3-bit, constants below)
//   AXI_SIZE_*        AXI size encodings used for usize/arsize/awsize
//   AXI_RESP_OKAY     good response code on rresp/bresp
//   AXI_BURST_INCR    burst type driven on arburst/awburst
//   AXI_LEN_SINGLE    single-beat burst length
//   AXI_CACHE_*, AXI_PROT_*, AXI_LOCK_*  tie-offs for uncached device access
//   size_strobe()     byte-lane mask for a naturally aligned access
// -----------------------------------------------------------------------------
package uncache_axi_bridge_pkg;

    typedef logic [2:0] uc_state_t;

    localparam uc_state_t IDLE   = 3'd0;
    localparam uc_state_t RD_A   = 3'd1;
    localparam uc_state_t RD_D   = 3'd2;
    localparam uc_state_t RD_RSP = 3'd3;
    localparam uc_state_t WR_AW  = 3'd4;
    localparam uc_state_t WR_B   = 3'd5;

    localparam logic [2:0] AXI_SIZE_BYTE = 3'b000;
    localparam logic [2:0] AXI_SIZE_HALF = 3'b001;
    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // Device, non-bufferable, unprivileged secure data access, no exclusives.
    localparam logic [3:0] AXI_CACHE_DEVICE = 4'b0000;
    localparam logic [2:0] AXI_PROT_DATA    = 3'b000;
    localparam logic       AXI_LOCK_NORMAL  = 1'b0;

    // Lanes touched by an aligned access of the given size. Any size code
    // other than byte/half is treated as a full word.
    function automatic logic [3:0] size_strobe(input logic [2:0] usize,
                                               input logic [1:0] addr_lo);
        logic [3:0] m;
        case (usize)
            AXI_SIZE_BYTE: m = 4'b0001 << addr_lo;
            AXI_SIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:       m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uncache_axi_bridge_if.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge_if
// AXI4 single-ID master/slave bundle for the uncache bridge.
//   master modport: drives AR/AW/W address+data and R/B ready; samples the rest
//   slave  modport: the opposite direction (memory side / crossbar port)
// Handshake rule on every channel: a beat transfers on a rising clk edge where
// valid & ready are both 1; the source holds valid and payload stable until
// then, and valid never waits on ready.
// -----------------------------------------------------------------------------
interface uncache_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arlock;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awlock;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/uncache_axi_bridge.sv
// -----------------------------------------------------------------------------
// uncache_axi_bridge
// Turns one uncached LSU request at a time into a single-beat AXI4 transaction.
// Only one transaction is ever outstanding, so MMIO ordering is preserved.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   uvalid/mready   request handshake (mready high only when idle)
//   uwen            1 = write, 0 = read
//   uaddr, udata    byte address and lane-aligned write data
//   usize, ustrobe  AXI size code and byte-enable mask
//   mvalid/uready   read-data handshake; mdata holds the raw bus word
//   bus_err         one-cycle pulse after a non-OKAY rresp/bresp
//   state           current FSM state, for observation
//   axi             AXI4 master port
// -----------------------------------------------------------------------------
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
#(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uvalid,
    input  logic                 uwen,
    input  logic [ADDR_W-1:0]    uaddr,
    input  logic [DATA_W-1:0]    udata,
    input  logic [2:0]           usize,
    input  logic [3:0]           ustrobe,
    output logic                 mready,
    output logic                 mvalid,
    output logic [DATA_W-1:0]    mdata,
    input  logic                 uready,
    output logic                 bus_err,
    output uc_state_t            state,
    uncache_axi_bridge_if.master axi
);

    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [2:0]        req_size;
    logic [3:0]        req_strb;
    logic              aw_done;
    logic              w_done;

    logic accept;
    logic ar_fire;
    logic r_fire;
    logic aw_fire;
    logic w_fire;
    logic b_fire;

    assign mready = (state == IDLE);
    assign mvalid = (state == RD_RSP);
    assign accept = uvalid & mready;

    assign axi.arvalid = (state == RD_A);
    assign axi.rready  = (state == RD_D);
    // AW and W are offered together; each drops on its own handshake.
    assign axi.awvalid = (state == WR_AW) & ~aw_done;
    assign axi.wvalid  = (state == WR_AW) & ~w_done;
    assign axi.bready  = (state == WR_B);

    assign ar_fire = axi.arvalid & axi.arready;
    assign r_fire  = axi.rvalid  & axi.rready;
    assign aw_fire = axi.awvalid & axi.awready;
    assign w_fire  = axi.wvalid  & axi.wready;
    assign b_fire  = axi.bvalid  & axi.bready;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = req_addr;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = req_size;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arcache = AXI_CACHE_DEVICE;
    assign axi.arprot  = AXI_PROT_DATA;
    assign axi.arlock  = AXI_LOCK_NORMAL;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = req_addr;
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = req_size;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awcache = AXI_CACHE_DEVICE;
    assign axi.awprot  = AXI_PROT_DATA;
    assign axi.awlock  = AXI_LOCK_NORMAL;

    assign axi.wdata = req_data;
    assign axi.wstrb = req_strb;
    assign axi.wlast = 1'b1;

    // IDs and rlast carry no information with one ID and single beats.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{axi.rid, axi.rlast, axi.bid};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mdata    <= '0;
            bus_err  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            req_size <= '0;
            req_strb <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr <= uaddr;
                        req_data <= udata;
                        req_size <= usize;
                        req_strb <= ustrobe & size_strobe(usize, uaddr[1:0]);
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        state    <= uwen ? WR_AW : RD_A;
                    end
                end
                RD_A: begin
                    if (ar_fire) state <= RD_D;
                end
                RD_D: begin
                    if (r_fire) begin
                        mdata   <= axi.rdata;
                        bus_err <= (axi.rresp != AXI_RESP_OKAY);
                        state   <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (uready) state <= IDLE;
                end
                WR_AW: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                    // Join: the channel finishing last may do so this very edge.
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        state <= WR_B;
                    end
                end
                WR_B: begin
                    if (b_fire) begin
                        bus_err <= (axi.bresp != AXI_RESP_OKAY);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
